bcd_a_binario: RTL and testbench
================================

# bcd_a_binario

Sequential converter from signed 5-digit BCD (sign + 20-bit magnitude, same packing as the display path's `codigo_BCD`) back to 16-bit two's complement. It uses a reverse double-dabble (shift-right, subtract-3) datapath. It sits between a BCD entry source (keypad or switch digit entry) and the Booth multiplier operand path. It validates digits, detects range overflow and reports completion with a one-cycle `done` pulse.

## Interface
- No parameters; widths are fixed.
- `CLK100MHZ`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high; clock CLK100MHZ.
- `start`  in  1  request conversion; sampled only in IDLE.
- `codigo_BCD`  in  21  bit 20 = sign (1 = negative); bits 19:0 = five BCD digits, MSD in 19:16.
- `resultado`  out  16  two's-complement result, registered.
- `done`  out  1  one-cycle pulse when `resultado` and flags update.
- `busy`  out  1  high while a conversion is in progress.
- `err_digito`  out  1  some nibble > 9 in the last accepted input.
- `overflow`  out  1  magnitude out of 16-bit signed range in the last conversion.

## Operation
- States: IDLE, CHECK, SHIFT, SIGN.
- IDLE: `start`=1 latches `codigo_BCD` into the sign register and the 20-bit BCD register. It also clears the 17-bit binary shift register, sets `busy`=1 and moves to CHECK.
- CHECK: if any nibble > 9, the block sets `err_digito`=1, `overflow`=0, `resultado`=0, `done`=1, `busy`=0, then returns to IDLE. Otherwise it clears the iteration counter and moves to SHIFT.
- SHIFT, 17 iterations, one per cycle:
  - Shift {BCD, bin} right by 1; the BCD LSB enters bin MSB.
  - Then, on the shifted value, subtract 3 from every BCD digit that is ≥ 8.
  - After iteration 17 (counter 16), go to SIGN.
- SIGN: bin holds the magnitude m (0..99999).
  - Overflow: sign=0 and m > 32767, or sign=1 and m > 32768.
  - No overflow: `resultado` = sign ? −m : m, truncated to 16 bits.
  - Overflow: see Configuration.
  - Set `err_digito`=0, `done`=1, `busy`=0, return to IDLE.
- Negative zero (sign=1, m=0) gives 0x0000 with `overflow`=0.
- `resultado`, `err_digito` and `overflow` hold their values until the next completion. `done` is cleared on the following edge.
- `start` while `busy`=1 is ignored and not queued. `start` during the `done` cycle is accepted, because the FSM is already in IDLE.

## Timing
- Reset values: `resultado`=0x0000, `done`=0, `busy`=0, `err_digito`=0, `overflow`=0. State is IDLE and the internal registers are 0.
- With `start` sampled at edge k:
  - `busy` is high after edge k.
  - Valid input: SHIFT runs on edges k+2..k+18; SIGN at edge k+19 updates the outputs. `done`=1 and `busy`=0 during the cycle after edge k+19, so latency is 19 cycles.
  - Invalid digit: outputs update at edge k+1, so latency is 1 cycle.
- `codigo_BCD` may change freely after edge k.
- `reset` mid-conversion: on the next edge the FSM returns to IDLE and all outputs take their reset values. No `done` is issued for the aborted conversion.
- `reset` and `start` together: `reset` wins and `start` is dropped.

## Configuration
- `BCD_SATURATE_EN`, defined: on overflow, `resultado` saturates to 0x7FFF (positive) or 0x8000 (negative), with `overflow`=1.
- Not defined: on overflow, `resultado` = low 16 bits of ±m (wrapped), still with `overflow`=1.
- All other behaviour and all timing are identical in both builds.

## Test plan
- Positive value: `codigo_BCD`={0,0x12345}, `start` pulse → `done` 19 cycles later, `resultado`=0x3039, both flags 0, `busy` high exactly 19 cycles.
- Negative value and negative zero: {1,0x00100} → 0xFF9C. {1,0x00000} → 0x0000, `overflow`=0.
- Range boundaries:
  - {1,0x32768} → 0x8000, `overflow`=0.
  - {0,0x32767} → 0x7FFF, `overflow`=0.
  - {0,0x32768} → `overflow`=1; 0x7FFF with `BCD_SATURATE_EN`, 0x8000 without.
- Maximum input: {0,0x99999} → `overflow`=1; 0x7FFF with `BCD_SATURATE_EN`, 0x869F without.
- Invalid digit: {0,0x1A345} → `done` one cycle after the start edge, `err_digito`=1, `resultado`=0x0000. The next valid conversion clears `err_digito`.
- Control events:
  - `start` re-pulsed at cycle 5 of a conversion → ignored, single `done`.
  - `reset` at cycle 8 → no `done`, all outputs 0.
  - `start` during a `done` cycle → a new conversion completes 19 cycles later.

Source files
------------

// File: rtl/bcd_a_binario.sv
// Signed 5-digit BCD to 16-bit two's complement converter (reverse double-dabble).
// Optional build macro: BCD_SATURATE_EN (saturate instead of wrap on range overflow).
module bcd_a_binario (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic        start,
  input  logic [20:0] codigo_BCD,
  output logic [15:0] resultado,
  output logic        done,
  output logic        busy,
  output logic        err_digito,
  output logic        overflow,
  output logic [1:0]  estado_dbg
);

  // start is a level sampled only in IDLE; done is a one-cycle pulse with the
  // registered results, which then hold until the next completion.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SHIFT = 2'd2,
    SIGN  = 2'd3
  } estado_t;

  estado_t     state_q, state_d;
  logic        sign_q, sign_d;
  logic [19:0] bcd_q, bcd_d;
  logic [16:0] bin_q, bin_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] res_q, res_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        ovf_q, ovf_d;

  logic [36:0] shifted;
  logic [19:0] bcd_sh;
  logic [16:0] bin_sh;
  logic        digit_bad;
  logic        ovf_now;
  logic [15:0] mag_neg;
  logic [15:0] wrapped;
  logic [15:0] final_res;

  always_comb begin
    shifted = {bcd_q, bin_q} >> 1;
    bin_sh  = shifted[16:0];
    bcd_sh  = shifted[36:17];
    for (int i = 0; i < 5; i++) begin
      if (shifted[17 + 4*i +: 4] >= 4'd8) begin
        bcd_sh[4*i +: 4] = shifted[17 + 4*i +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    digit_bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] > 4'd9) digit_bad = 1'b1;
    end
  end

  // Negative range reaches one further than positive (-32768 is representable).
  always_comb begin
    ovf_now = sign_q ? (bin_q > 17'd32768) : (bin_q > 17'd32767);
    mag_neg = 16'd0 - bin_q[15:0];
    wrapped = sign_q ? mag_neg : bin_q[15:0];
`ifdef BCD_SATURATE_EN
    if (ovf_now) final_res = sign_q ? 16'h8000 : 16'h7FFF;
    else         final_res = wrapped;
`else
    final_res = wrapped;
`endif
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d  = codigo_BCD[20];
          bcd_d   = codigo_BCD[19:0];
          bin_d   = 17'd0;
          busy_d  = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (digit_bad) begin
          err_d   = 1'b1;
          ovf_d   = 1'b0;
          res_d   = 16'h0000;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d   = 5'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = bcd_sh;
        bin_d = bin_sh;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd16) state_d = SIGN;
      end
      SIGN: begin
        res_d   = final_res;
        ovf_d   = ovf_now;
        err_d   = 1'b0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      bcd_q   <= 20'd0;
      bin_q   <= 17'd0;
      cnt_q   <= 5'd0;
      res_q   <= 16'h0000;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign resultado  = res_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign err_digito = err_q;
  assign overflow   = ovf_q;
  assign estado_dbg = state_q;

endmodule

// File: tb/tb_bcd_a_binario.sv
// Bench for bcd_a_binario: arithmetic reference model, expected-result queue,
// scenario tasks for conversions, boundaries, invalid digits and control events.
module tb_bcd_a_binario;

  logic        clk;
  logic        reset;
  logic        start;
  logic [20:0] codigo_BCD;
  logic [15:0] resultado;
  logic        done;
  logic        busy;
  logic        err_digito;
  logic        overflow;
  logic [1:0]  estado_dbg;

  int errors = 0;
  int checks = 0;

  // Packed expectation: {err_digito, overflow, resultado}
  logic [17:0] exp_q[$];

  bcd_a_binario dut (
    .CLK100MHZ (clk),
    .reset     (reset),
    .start     (start),
    .codigo_BCD(codigo_BCD),
    .resultado (resultado),
    .done      (done),
    .busy      (busy),
    .err_digito(err_digito),
    .overflow  (overflow),
    .estado_dbg(estado_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [17:0] model(input logic s, input logic [19:0] b);
    int          m = 0;
    int          v;
    logic        bad = 1'b0;
    logic        ovf;
    logic [15:0] res;
    logic [3:0]  d;
    for (int i = 4; i >= 0; i--) begin
      d = b[4*i +: 4];
      if (d > 4'd9) bad = 1'b1;
      m = m * 10 + int'(d);
    end
    if (bad) return {1'b1, 1'b0, 16'h0000};
    ovf = s ? (m > 32768) : (m > 32767);
    v   = s ? -m : m;
    res = v[15:0];
`ifdef BCD_SATURATE_EN
    if (ovf) res = s ? 16'h8000 : 16'h7FFF;
`endif
    return {1'b0, ovf, res};
  endfunction

  // ---------------- driver tasks ----------------
  // Drives a start pulse on the current negedge and records the expectation.
  task automatic drive_start(input logic s, input logic [19:0] b);
    codigo_BCD = {s, b};
    start      = 1'b1;
    exp_q.push_back(model(s, b));
    @(negedge clk);
    start      = 1'b0;
    codigo_BCD = 21'($urandom);
  endtask

  // Waits (bounded) for done; reports cycles since the start edge and busy cycles.
  task automatic wait_done(output int lat, output int busy_cyc, output logic [18:0] got);
    lat      = 0;
    busy_cyc = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cyc++;
      @(negedge clk);
      lat++;
    end
    got = {done, err_digito, overflow, resultado};
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({resultado, done, busy, err_digito, overflow} !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs: got res=%h done=%b busy=%b err=%b ovf=%b, need all zero",
               resultado, done, busy, err_digito, overflow);
    end
    checks++;
    if (estado_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d, need 0 (IDLE)", estado_dbg);
    end
  endtask

  // Table of {sign, bcd} conversions, each checked for value, flags, latency, busy.
  task automatic test_conversions();
    logic [20:0] tbl[9];
    int          lat, bc;
    logic [18:0] got, exp;
    tbl = '{ {1'b0, 20'h12345}, {1'b1, 20'h00100}, {1'b1, 20'h00000},
             {1'b1, 20'h32768}, {1'b0, 20'h32767}, {1'b0, 20'h32768},
             {1'b0, 20'h99999}, {1'b1, 20'h99999}, {1'b1, 20'h32769} };
    foreach (tbl[i]) begin
      drive_start(tbl[i][20], tbl[i][19:0]);
      wait_done(lat, bc, got);
      exp = {1'b1, exp_q.pop_front()};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL conv[%0d] in=%h: got {done,err,ovf,res}=%h, need %h", i, tbl[i], got, exp);
      end
      checks++;
      if (lat !== 19 || bc !== 19) begin
        errors++;
        $display("FAIL conv_timing[%0d]: got latency=%0d busy=%0d, need 19/19", i, lat, bc);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL conv_busy_at_done[%0d]: got %b, need 0", i, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || resultado !== exp[15:0]) begin
        errors++;
        $display("FAIL conv_hold[%0d]: got done=%b res=%h, need 0/%h", i, done, resultado, exp[15:0]);
      end
    end
  endtask

  task automatic test_invalid_digit();
    int          lat, bc;
    logic [18:0] got, exp;
    drive_start(1'b0, 20'h1A345);
    wait_done(lat, bc, got);
    exp = {1'b1, exp_q.pop_front()};
    checks++;
    if (got !== exp || lat !== 1) begin
      errors++;
      $display("FAIL invalid_digit: got %h lat=%0d, need %h lat=1", got, lat, exp);
    end
    @(negedge clk);
    drive_start(1'b0, 20'h00042);
    wait_done(lat, bc, got);
    exp = {1'b1, exp_q.pop_front()};
    checks++;
    if (got !== exp || lat !== 19) begin
      errors++;
      $display("FAIL err_clear: got %h lat=%0d, need %h lat=19", got, lat, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_restart_ignored();
    int          lat, bc, n_done;
    logic [18:0] got, exp;
    drive_start(1'b0, 20'h00777);
    repeat (4) @(negedge clk);
    codigo_BCD = {1'b1, 20'h00555};
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc, got);
    exp = {1'b1, exp_q.pop_front()};
    checks++;
    if (got !== exp || lat !== 14) begin
      errors++;
      $display("FAIL restart_ignored: got %h lat=%0d, need %h lat=14", got, lat, exp);
    end
    n_done = 0;
    repeat (25) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    checks++;
    if (n_done !== 0) begin
      errors++;
      $display("FAIL restart_single_done: got %0d extra done pulses, need 0", n_done);
    end
  endtask

  task automatic test_reset_abort();
    int n_done;
    drive_start(1'b0, 20'h04321);
    void'(exp_q.pop_back());   // conversion is aborted, never completes
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({resultado, done, busy, err_digito, overflow} !== 20'd0) begin
      errors++;
      $display("FAIL reset_abort_outputs: got res=%h done=%b busy=%b err=%b ovf=%b, need zero",
               resultado, done, busy, err_digito, overflow);
    end
    n_done = 0;
    repeat (25) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    checks++;
    if (n_done !== 0) begin
      errors++;
      $display("FAIL reset_abort_done: got %0d done pulses, need 0", n_done);
    end
    codigo_BCD = {1'b0, 20'h00123};
    start = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || estado_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_beats_start: got busy=%b state=%0d, need 0/0", busy, estado_dbg);
    end
  endtask

  task automatic test_back_to_back();
    int          lat, bc;
    logic [18:0] got, exp;
    drive_start(1'b1, 20'h01234);
    wait_done(lat, bc, got);
    exp = {1'b1, exp_q.pop_front()};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL b2b_first: got %h, need %h", got, exp);
    end
    drive_start(1'b0, 20'h20000);   // driven during the done cycle
    wait_done(lat, bc, got);
    exp = {1'b1, exp_q.pop_front()};
    checks++;
    if (got !== exp || lat !== 19) begin
      errors++;
      $display("FAIL b2b_second: got %h lat=%0d, need %h lat=19", got, lat, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int          lat, bc, exp_lat;
    logic [19:0] b;
    logic        s;
    logic [18:0] got, exp;
    for (int n = 0; n < 12; n++) begin
      for (int d = 0; d < 5; d++) b[4*d +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 5) == 0) b[4*$urandom_range(0, 4) +: 4] = 4'($urandom_range(10, 15));
      s = 1'($urandom_range(0, 1));
      drive_start(s, b);
      wait_done(lat, bc, got);
      exp     = {1'b1, exp_q.pop_front()};
      exp_lat = exp[17] ? 1 : 19;
      checks++;
      if (got !== exp || lat !== exp_lat) begin
        errors++;
        $display("FAIL random[%0d] in=%b_%h: got %h lat=%0d, need %h lat=%0d",
                 n, s, b, got, lat, exp, exp_lat);
      end
      @(negedge clk);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    codigo_BCD = 21'd0;
    @(negedge clk);
    test_reset();
    test_conversions();
    test_invalid_digit();
    test_restart_ignored();
    test_reset_abort();
    test_back_to_back();
    test_random();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, need 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
